adder_feed: RTL



---
 rtl/adder_feed.sv | 134 +++++++++++++
 1 files changed

// File: rtl/adder_feed.sv
// adder_feed: stream-to-parallel operand collector for the adder tree.
//
// Gathers NUM words of BITS width from a valid/ready stream into a frame and
// presents the whole frame in parallel with a one-cycle out_valid pulse.
// A frame ends when word NUM-1 is accepted or when a word with in_last is
// accepted. Short frames (in_last before word NUM-1) are either zero-padded
// and emitted, or discarded with a drop_err pulse.
//
// Build option: define ADDER_FEED_PAD_EN to zero-pad and emit short frames;
// leave it undefined to drop them and pulse drop_err.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   word present on in_data
//   in_data    operand word
//   in_last    final word of a frame (qualified by in_valid)
//   in_ready   block can accept a word (1 whenever rst is low)
//   out_valid  one-cycle pulse, out_data holds a new frame
//   out_data   frame, word i at [i*BITS +: BITS], word 0 first accepted
//   drop_err   one-cycle pulse, a short frame was discarded
//   fill_cnt   words accepted into the current partial frame
//
// state   | meaning
// S_EMPTY | no words held, fill_cnt = 0
// S_FILL  | partial frame held, fill_cnt in 1..NUM-1
module adder_feed #(
  parameter int BITS = 8,
  parameter int NUM  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [BITS-1:0]       in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [NUM*BITS-1:0]   out_data,
  output logic                  drop_err,
  output logic [$clog2(NUM):0]  fill_cnt
);

  localparam int CW = $clog2(NUM) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM - 1);

  typedef enum logic {S_EMPTY, S_FILL} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM*BITS-1:0]  buf_q, buf_d;
  logic [NUM*BITS-1:0]  out_q, out_d;
  logic                 ov_q, ov_d;
  logic                 de_q, de_d;

  logic                 accept;
  logic                 at_last;
  logic                 frame_end;
  logic                 short_end;
  logic                 emit;
  logic                 drop;
  logic [NUM*BITS-1:0]  frame_w;

  assign in_ready  = ~rst;
  assign accept    = in_valid & in_ready;
  assign at_last   = (cnt_q == LAST_IDX);
  assign frame_end = accept & (at_last | in_last);
  assign short_end = frame_end & ~at_last;

  // Buffer with the incoming word merged in. Slots above the write index are
  // always zero because the buffer clears at every frame end, which is what
  // makes a padded short frame come out correctly.
  always_comb begin
    frame_w = buf_q;
    for (int i = 0; i < NUM; i++) begin
      if (cnt_q == CW'(i)) frame_w[i*BITS +: BITS] = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
      buf_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      de_q    <= de_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept && !frame_end) state_d = S_FILL;
      S_FILL:  if (frame_end)            state_d = S_EMPTY;
      default:                           state_d = S_EMPTY;
    endcase

    cnt_d = cnt_q;
    buf_d = buf_q;
    if (frame_end) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
      buf_d = frame_w;
    end
  end

  always_comb begin
`ifdef ADDER_FEED_PAD_EN
    emit = frame_end;
    drop = 1'b0;
`else
    emit = frame_end & ~short_end;
    drop = short_end;
`endif
    out_d = emit ? frame_w : out_q;
    ov_d  = emit;
    de_d  = drop;
  end

  assign out_valid = ov_q;
  assign out_data  = out_q;
  assign drop_err  = de_q;
  assign fill_cnt  = cnt_q;

endmodule
